uart_rx_fifo_wr: RTL and testbench

- UART 8N1 receiver that sits directly upstream of the 16x8 FIFO and pushes each received byte into it.
- Oversamples the serial line using a clock-cycle divider and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB-first, checks the stop bit, then drives the FIFO write port (din/wr) while honouring the FIFO full flag.
- Flags framing errors, and overruns where a byte is dropped because the FIFO is full.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_fifo_wr_if.sv | 27 ++
 rtl/uart_rx_fifo_wr_bit_sync.sv | 13 +
 rtl/uart_rx_fifo_wr.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo_wr.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared states, default sizes and parity helper for the UART receiver
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int CLKS_PER_BIT = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_wr_if.sv
// uart_rx_fifo_wr_if: serial input, FIFO write port and status bundle; parity_err exists only with UART_RX_PARITY_EN
interface uart_rx_fifo_wr_if #(parameter int DATA_W = 8);
  logic rxd;
  logic full;
  logic [DATA_W-1:0] din;
  logic wr;
  logic frame_err;
  logic overrun;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  modport master (
    input rxd, full,
    output din, wr, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );
  modport slave (
    output rxd, full,
    input din, wr, frame_err, overrun, busy
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/uart_rx_fifo_wr_bit_sync.sv
// bit_sync: two-flop synchroniser for an asynchronous input that idles high
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async input through two flops; reset to the idle-high level
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_fifo_wr.sv
// uart_rx_fifo_wr: UART 8N1 receiver pushing bytes into a FIFO; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx_fifo_wr #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_wr_if.master bus
);
  import uart_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TOP = BW'(DATA_W - 1);
  state_t state;
  logic armed;
  logic rxd_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_W-1:0] sh;
`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif
  bit_sync u_sync (.clk(clk), .rst(rst), .d(bus.rxd), .q(rxd_s));
  assign bus.busy = state != IDLE;
  // frame FSM; the start bit is checked at half a bit so later samples land mid-bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      bus.din <= '0;
      bus.wr <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      bus.wr <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rxd_s) armed <= 1'b1;
          else if (armed) begin
            state <= START;
            armed <= 1'b0;
          end
        end
        START:
          if (cnt == HALF) begin
            cnt <= '0;
            bit_idx <= '0;
            state <= rxd_s ? IDLE : DATA;
          end
        DATA:
          if (cnt == LAST) begin
            cnt <= '0;
            sh <= {rxd_s, sh[DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == TOP) state <= PARITY;
`else
            if (bit_idx == TOP) state <= STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (cnt == LAST) begin
            cnt <= '0;
            par_bad <= rxd_s != parity(sh);
            state <= STOP;
          end
`endif
        STOP:
          if (cnt == LAST) begin
            cnt <= '0;
            state <= IDLE;
            armed <= rxd_s;
            if (!rxd_s) bus.frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_bad) bus.parity_err <= 1'b1;
`endif
            else if (bus.full) bus.overrun <= 1'b1;
            else begin
              bus.wr <= 1'b1;
              bus.din <= sh;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// tb_uart_rx_fifo_wr: directed frames against a 16-deep FIFO occupancy model
module tb_uart_rx_fifo_wr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic force_full = 1'b0;
  int tests = 0, fails = 0;
  int cyc = 0, wr_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, wr_cyc = 0, fifo_base = 0;
  logic [7:0] din_log [0:63];
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif
  always #5 clk = ~clk;
  uart_rx_fifo_wr_if #(.DATA_W(8)) bus ();
  uart_rx_fifo_wr #(.CLKS_PER_BIT(16), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.full = force_full || (wr_cnt - fifo_base >= 16);
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.wr) begin
      din_log[wr_cnt % 64] = bus.din;
      wr_cnt++;
      wr_cyc = cyc;
    end
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err) pe_cnt++;
`endif
  end

  task automatic bit_out(input logic b);
    bus.rxd = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ bad_par);
`endif
    bit_out(stop_b);
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rxd = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.din !== 8'h00) begin fails++; $display("FAIL reset_din got %h want 00", bus.din); end
    tests++; if (bus.wr !== 1'b0) begin fails++; $display("FAIL reset_wr got %b want 0", bus.wr); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b1;
    idle(20);
  endtask

  task automatic test_valid();
    int w0, f0, o0, t0;
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL valid_wr_count got %0d want 1", wr_cnt - w0); end
    tests++; if (din_log[w0 % 64] !== 8'hA5) begin fails++; $display("FAIL valid_din got %h want a5", din_log[w0 % 64]); end
    tests++; if (wr_cyc - t0 < 153 || wr_cyc - t0 > 157) begin fails++; $display("FAIL valid_latency got %0d want 155", wr_cyc - t0); end
    tests++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin fails++; $display("FAIL valid_errors got fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL valid_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_glitch();
    int w0, f0, t0, last_busy;
    logic saw_busy;
    w0 = wr_cnt; f0 = fe_cnt;
    saw_busy = 1'b0; last_busy = 0;
    t0 = cyc;
    bus.rxd = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 3) bus.rxd = 1'b1;
      if (bus.busy) begin saw_busy = 1'b1; last_busy = cyc - t0; end
    end
    idle(10);
    tests++; if (saw_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_seen got %b want 1", saw_busy); end
    tests++; if (last_busy > 11) begin fails++; $display("FAIL glitch_busy_drop got last busy at %0d want <= 11", last_busy); end
    tests++; if (wr_cnt - w0 !== 0 || fe_cnt - f0 !== 0) begin fails++; $display("FAIL glitch_no_output got wr=%0d fe=%0d want 0 0", wr_cnt - w0, fe_cnt - f0); end
  endtask

  task automatic test_frame_err();
    int w0, f0;
    w0 = wr_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    idle(20);
    tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL frame_err_pulse got %0d want 1", fe_cnt - f0); end
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL frame_err_no_wr got %0d want 0", wr_cnt - w0); end
    send_frame(8'h3C, 1'b1);
    idle(20);
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL frame_err_recover_wr got %0d want 1", wr_cnt - w0); end
    tests++; if (bus.din !== 8'h3C) begin fails++; $display("FAIL frame_err_recover_din got %h want 3c", bus.din); end
    tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL frame_err_single got %0d want 1", fe_cnt - f0); end
  endtask

  task automatic test_overrun();
    int w0, o0;
    w0 = wr_cnt; o0 = ov_cnt;
    force_full = 1'b1;
    send_frame(8'h11, 1'b1);
    idle(20);
    force_full = 1'b0;
    tests++; if (ov_cnt - o0 !== 1) begin fails++; $display("FAIL overrun_pulse got %0d want 1", ov_cnt - o0); end
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL overrun_no_wr got %0d want 0", wr_cnt - w0); end
    tests++; if (bus.din !== 8'h3C) begin fails++; $display("FAIL overrun_din_held got %h want 3c", bus.din); end
    send_frame(8'h22, 1'b1);
    idle(20);
    tests++; if (wr_cnt - w0 !== 1 || bus.din !== 8'h22) begin fails++; $display("FAIL overrun_next got wr=%0d din=%h want 1 22", wr_cnt - w0, bus.din); end
  endtask

  task automatic test_back_to_back();
    int w0, o0;
    logic [7:0] d;
    fifo_base = wr_cnt;
    w0 = wr_cnt; o0 = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, 1'b1);
    end
    idle(20);
    tests++; if (wr_cnt - w0 !== 16) begin fails++; $display("FAIL b2b_wr_count got %0d want 16", wr_cnt - w0); end
    tests++; if (ov_cnt - o0 !== 2) begin fails++; $display("FAIL b2b_overrun_count got %0d want 2", ov_cnt - o0); end
    tests++; if (din_log[w0 % 64] !== 8'h00 || din_log[(w0 + 1) % 64] !== 8'hFF) begin fails++; $display("FAIL b2b_first got %h %h want 00 ff", din_log[w0 % 64], din_log[(w0 + 1) % 64]); end
    tests++; if (din_log[(w0 + 15) % 64] !== 8'h1D) begin fails++; $display("FAIL b2b_last got %h want 1d", din_log[(w0 + 15) % 64]); end
    tests++; if (bus.din !== 8'h1D) begin fails++; $display("FAIL b2b_din_held got %h want 1d", bus.din); end
    fifo_base = wr_cnt;
  endtask

  task automatic test_reset_mid();
    int w0;
    logic [7:0] d;
    w0 = wr_cnt;
    d = 8'h5A;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(d[i]);
    rst = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.wr !== 1'b0 || bus.din !== 8'h00) begin fails++; $display("FAIL reset_mid_outputs got busy=%b wr=%b din=%h want 0 0 00", bus.busy, bus.wr, bus.din); end
    bus.rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle(100);
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL reset_mid_no_wr got %0d want 0", wr_cnt - w0); end
    send_frame(8'hC3, 1'b1);
    idle(20);
    tests++; if (wr_cnt - w0 !== 1 || bus.din !== 8'hC3) begin fails++; $display("FAIL reset_mid_next got wr=%0d din=%h want 1 c3", wr_cnt - w0, bus.din); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int w0, p0;
    w0 = wr_cnt; p0 = pe_cnt;
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(20);
    bad_par = 1'b0;
    tests++; if (pe_cnt - p0 !== 1) begin fails++; $display("FAIL parity_err_pulse got %0d want 1", pe_cnt - p0); end
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL parity_no_wr got %0d want 0", wr_cnt - w0); end
    send_frame(8'h07, 1'b1);
    idle(20);
    tests++; if (wr_cnt - w0 !== 1 || bus.din !== 8'h07) begin fails++; $display("FAIL parity_good got wr=%0d din=%h want 1 07", wr_cnt - w0, bus.din); end
  endtask
`endif

  initial begin
    bus.rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_valid();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
